// File: rtl/ysyx_23060077_csr_trap.sv
// Machine-mode CSR file with ecall/mret/timer-interrupt trap handling.
// Optional mcycle/minstret counters are built only when CSR_COUNTER_EN is defined.
module ysyx_23060077_csr_trap #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            irq_take_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            inst_retire_i,
  input  logic            timer_irq_i,
  output logic            irq_pending_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic [XLEN-1:0] mret_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
`ifdef CSR_COUNTER_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
`endif

  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] csr_new;
  logic [XLEN-1:0] trap_base;
  logic            csr_we;

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
`else
  logic unused_retire;
  assign unused_retire = inst_retire_i;
`endif

  // Read path always reflects the value before this cycle's update.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rdata[3]     = mstatus_mie;
        csr_rdata[7]     = mstatus_mpie;
        csr_rdata[12:11] = 2'b11;
      end
      ADDR_MIE:       csr_rdata[7] = mie_mtie;
      ADDR_MTVEC:     csr_rdata = mtvec;
      ADDR_MSCRATCH:  csr_rdata = mscratch;
      ADDR_MEPC:      csr_rdata = mepc;
      ADDR_MCAUSE:    csr_rdata = mcause;
      ADDR_MIP:       csr_rdata[7] = timer_irq_i;
      ADDR_MVENDORID: csr_rdata = XLEN'(32'h7973_7978);
      ADDR_MARCHID:   csr_rdata = XLEN'(32'h015F_DE6D);
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE:    csr_rdata = XLEN'(mcycle);
      ADDR_MINSTRET:  csr_rdata = XLEN'(minstret);
      ADDR_MCYCLEH:   if (XLEN == 32) csr_rdata = XLEN'(mcycle >> 32);
      ADDR_MINSTRETH: if (XLEN == 32) csr_rdata = XLEN'(minstret >> 32);
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  // Any trap or mret in the same cycle swallows the CSR instruction.
  assign csr_we = (csr_op != 2'b00) && !irq_take_i && !ecall_i && !mret_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
    end else if (irq_take_i) begin
      mepc         <= pc_i & ~XLEN'(1);
      mcause       <= {1'b1, (XLEN-1)'(7)};
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (ecall_i) begin
      mepc         <= pc_i & ~XLEN'(1);
      mcause       <= XLEN'(11);
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie  <= csr_new[3];
          mstatus_mpie <= csr_new[7];
        end
        ADDR_MIE:      mie_mtie <= csr_new[7];
        ADDR_MTVEC:    mtvec    <= csr_new & ~XLEN'(2);
        ADDR_MSCRATCH: mscratch <= csr_new;
        ADDR_MEPC:     mepc     <= csr_new & ~XLEN'(1);
        ADDR_MCAUSE:   mcause   <= csr_new;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTER_EN
  // A write to either half replaces that half and holds the counter this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (csr_we && csr_addr == ADDR_MCYCLE) begin
        if (XLEN == 64) mcycle <= 64'(csr_new);
        else            mcycle <= {mcycle[63:32], csr_new[31:0]};
      end else if (csr_we && csr_addr == ADDR_MCYCLEH && XLEN == 32) begin
        mcycle <= {csr_new[31:0], mcycle[31:0]};
      end else begin
        mcycle <= mcycle + 64'd1;
      end

      if (csr_we && csr_addr == ADDR_MINSTRET) begin
        if (XLEN == 64) minstret <= 64'(csr_new);
        else            minstret <= {minstret[63:32], csr_new[31:0]};
      end else if (csr_we && csr_addr == ADDR_MINSTRETH && XLEN == 32) begin
        minstret <= {csr_new[31:0], minstret[31:0]};
      end else if (inst_retire_i) begin
        minstret <= minstret + 64'd1;
      end
    end
  end
`endif

  assign trap_base     = {mtvec[XLEN-1:2], 2'b00};
  assign trap_pc_o     = (irq_take_i && mtvec[0]) ? trap_base + XLEN'(28) : trap_base;
  assign mret_pc_o     = mepc;
  assign irq_pending_o = mstatus_mie & mie_mtie & timer_irq_i;

endmodule

// File: tb/tb_ysyx_23060077_csr_trap.sv
// Self-checking bench for ysyx_23060077_csr_trap: vector table, trap sequences,
// and randomized traffic against an abstract CSR model.
module tb_ysyx_23060077_csr_trap;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0201;

  logic        clock;
  logic        reset;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        ecall_i;
  logic        mret_i;
  logic        irq_take_i;
  logic [31:0] pc_i;
  logic        inst_retire_i;
  logic        timer_irq_i;
  logic        irq_pending_o;
  logic [31:0] trap_pc_o;
  logic [31:0] mret_pc_o;

  int checks = 0;
  int errors = 0;

  ysyx_23060077_csr_trap #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clock(clock), .reset(reset), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .ecall_i(ecall_i),
    .mret_i(mret_i), .irq_take_i(irq_take_i), .pc_i(pc_i),
    .inst_retire_i(inst_retire_i), .timer_irq_i(timer_irq_i),
    .irq_pending_o(irq_pending_o), .trap_pc_o(trap_pc_o), .mret_pc_o(mret_pc_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  // Abstract model state
  bit          m_mie, m_mpie, m_mtie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_cycle(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_op = op; csr_addr = addr; csr_wdata = wd;
    tick();
    csr_op = 2'b00;
  endtask

  task automatic rd_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_op = 2'b00; csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a, input bit timer);
    case (a)
      12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h304: return m_mtie ? 32'h80 : 32'h0;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return timer ? 32'h80 : 32'h0;
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h015F_DE6D;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0;
    m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
  endtask

  task automatic model_step(input bit rst, input bit irq, input bit ec, input bit mr,
                            input logic [1:0] op, input logic [11:0] a,
                            input logic [31:0] wd, input logic [31:0] pc, input bit timer);
    logic [31:0] old, nv;
    if (rst) begin
      model_reset();
    end else if (irq || ec) begin
      m_mepc   = {pc[31:1], 1'b0};
      m_mcause = irq ? 32'h8000_0007 : 32'd11;
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (mr) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (op != 2'b00) begin
      old = model_read(a, timer);
      nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
      case (a)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mtie = nv[7];
        12'h305: m_mtvec = {nv[31:2], 1'b0, nv[0]};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = {nv[31:1], 1'b0};
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
  endtask

  logic [11:0] addr_pool[9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h344, 12'hF11, 12'h7C0};

  initial begin
    reset = 1; csr_addr = 0; csr_op = 0; csr_wdata = 0; ecall_i = 0; mret_i = 0;
    irq_take_i = 0; pc_i = 0; inst_retire_i = 0; timer_irq_i = 0;

    vecs[0]  = '{2'b01, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1]  = '{2'b10, 12'h340, 32'h0000_0010, 32'hDEAD_BEFF};
    vecs[2]  = '{2'b11, 12'h340, 32'hFFFF_0000, 32'h0000_BEFF};
    vecs[3]  = '{2'b00, 12'h340, 32'h0000_0001, 32'h0000_BEFF};
    vecs[4]  = '{2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
    vecs[5]  = '{2'b11, 12'h300, 32'h0000_0008, 32'h0000_1880};
    vecs[6]  = '{2'b01, 12'h300, 32'h0000_0000, 32'h0000_1800};
    vecs[7]  = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0000_0080};
    vecs[8]  = '{2'b01, 12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[9]  = '{2'b01, 12'h341, 32'h0000_1235, 32'h0000_1234};
    vecs[10] = '{2'b01, 12'h342, 32'h8000_000B, 32'h8000_000B};
    vecs[11] = '{2'b01, 12'hF11, 32'h0000_0000, 32'h7973_7978};
    vecs[12] = '{2'b01, 12'hF12, 32'h0000_0000, 32'h015F_DE6D};
    vecs[13] = '{2'b01, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[14] = '{2'b01, 12'h7C0, 32'h0000_FFFF, 32'h0000_0000};

    tick(); tick();
    reset = 0;
    #1;
    check("rst_pending", {31'b0, irq_pending_o}, 32'h0);
    check("rst_mret_pc", mret_pc_o, 32'h0);
    check("rst_trap_pc", trap_pc_o, 32'h0000_0200);
    rd_check("rst_mtvec", 12'h305, MTVEC_RST);
    rd_check("rst_mstatus", 12'h300, 32'h0000_1800);

    for (int i = 0; i < 15; i++) begin
      csr_cycle(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      rd_check($sformatf("tbl%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // ecall into direct-mode vector
    csr_cycle(2'b01, 12'h305, 32'h8000_0100);
    csr_cycle(2'b01, 12'h300, 32'h0000_0008);
    ecall_i = 1; pc_i = 32'h8000_0010;
    #1;
    check("ecall_trap_pc", trap_pc_o, 32'h8000_0100);
    tick();
    ecall_i = 0;
    rd_check("ecall_mepc", 12'h341, 32'h8000_0010);
    rd_check("ecall_mcause", 12'h342, 32'd11);
    rd_check("ecall_mstatus", 12'h300, 32'h0000_1880);

    mret_i = 1;
    tick();
    mret_i = 0;
    rd_check("mret_mstatus", 12'h300, 32'h0000_1888);
    check("mret_pc", mret_pc_o, 32'h8000_0010);

    // vectored timer interrupt
    csr_cycle(2'b01, 12'h305, 32'h8000_0101);
    csr_cycle(2'b01, 12'h304, 32'h0000_0080);
    timer_irq_i = 1;
    #1;
    check("irq_pending_hi", {31'b0, irq_pending_o}, 32'h1);
    rd_check("mip_read", 12'h344, 32'h0000_0080);
    irq_take_i = 1; pc_i = 32'h8000_0020;
    #1;
    check("irq_trap_pc", trap_pc_o, 32'h8000_011C);
    tick();
    irq_take_i = 0;
    #1;
    check("irq_pending_lo", {31'b0, irq_pending_o}, 32'h0);
    rd_check("irq_mcause", 12'h342, 32'h8000_0007);
    rd_check("irq_mepc", 12'h341, 32'h8000_0020);
    check("irq_trap_pc_after", trap_pc_o, 32'h8000_0100);
    timer_irq_i = 0;

    // ecall beats a simultaneous mepc write
    ecall_i = 1; pc_i = 32'h8000_0040;
    csr_cycle(2'b01, 12'h341, 32'h0000_1234);
    ecall_i = 0;
    rd_check("ecall_vs_write", 12'h341, 32'h8000_0040);

    // irq beats ecall; mret drops a CSR write
    csr_cycle(2'b01, 12'h300, 32'h0000_0008);
    csr_cycle(2'b01, 12'h340, 32'h0000_AAAA);
    irq_take_i = 1; ecall_i = 1; pc_i = 32'h0000_0100;
    tick();
    irq_take_i = 0; ecall_i = 0;
    rd_check("irq_vs_ecall", 12'h342, 32'h8000_0007);
    mret_i = 1;
    csr_cycle(2'b01, 12'h340, 32'h0000_0055);
    mret_i = 0;
    rd_check("mret_vs_write", 12'h340, 32'h0000_AAAA);
    rd_check("mret_mstatus2", 12'h300, 32'h0000_1888);

`ifdef CSR_COUNTER_EN
    csr_cycle(2'b01, 12'hB00, 32'hFFFF_FFFF);
    csr_cycle(2'b01, 12'hB80, 32'hFFFF_FFFF);
    rd_check("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
    rd_check("mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF);
    tick();
    rd_check("mcycle_lo_wrap", 12'hB00, 32'h0);
    rd_check("mcycle_hi_wrap", 12'hB80, 32'h0);
    csr_cycle(2'b01, 12'hB02, 32'h0);
    csr_cycle(2'b01, 12'hB82, 32'h0);
    inst_retire_i = 1;
    tick(); tick(); tick();
    inst_retire_i = 0;
    tick();
    rd_check("minstret", 12'hB02, 32'd3);
`else
    csr_cycle(2'b01, 12'hB00, 32'hFFFF_FFFF);
    rd_check("no_mcycle", 12'hB00, 32'h0);
    csr_cycle(2'b01, 12'hB82, 32'hFFFF_FFFF);
    rd_check("no_minstreth", 12'hB82, 32'h0);
`endif

    // reset mid-operation wins over a simultaneous ecall
    csr_cycle(2'b01, 12'h304, 32'h0000_0080);
    rd_check("pre_rst_mepc", 12'h341, 32'h0000_0100);
    reset = 1; ecall_i = 1; pc_i = 32'h0000_4444; timer_irq_i = 1;
    tick();
    reset = 0; ecall_i = 0;
    rd_check("rst2_mepc", 12'h341, 32'h0);
    rd_check("rst2_mie", 12'h304, 32'h0);
    rd_check("rst2_mtvec", 12'h305, MTVEC_RST);
    rd_check("rst2_mcause", 12'h342, 32'h0);
    check("rst2_pending", {31'b0, irq_pending_o}, 32'h0);
    check("rst2_trap_pc", trap_pc_o, 32'h0000_0200);
    check("rst2_mret_pc", mret_pc_o, 32'h0);
    timer_irq_i = 0;

    // randomized traffic against the model
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      logic [31:0] exp_tpc;
      bit rst_r, irq_r, ec_r, mr_r;
      r = $urandom;
      rst_r = (r[4:0] == 5'd0);
      irq_r = (r[7:5] == 3'd0);
      ec_r  = (r[10:8] == 3'd0);
      mr_r  = (r[13:11] == 3'd0);
      reset = rst_r; irq_take_i = irq_r; ecall_i = ec_r; mret_i = mr_r;
      csr_op = r[15:14];
      csr_addr = addr_pool[$urandom_range(0, 8)];
      csr_wdata = $urandom;
      pc_i = $urandom;
      timer_irq_i = r[16];
      #1;
      check($sformatf("rnd%0d_rdata", n), csr_rdata, model_read(csr_addr, timer_irq_i));
      check($sformatf("rnd%0d_pending", n), {31'b0, irq_pending_o},
            {31'b0, m_mie & m_mtie & timer_irq_i});
      exp_tpc = {m_mtvec[31:2], 2'b00};
      if (irq_r && m_mtvec[0]) exp_tpc = exp_tpc + 32'd28;
      check($sformatf("rnd%0d_trap_pc", n), trap_pc_o, exp_tpc);
      check($sformatf("rnd%0d_mret_pc", n), mret_pc_o, m_mepc);
      tick();
      model_step(rst_r, irq_r, ec_r, mr_r, csr_op, csr_addr, csr_wdata, pc_i, timer_irq_i);
    end
    reset = 0; irq_take_i = 0; ecall_i = 0; mret_i = 0; csr_op = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_csr_trap.md
YSYX_23060077_CSR_TRAP -- requirements
Module: ysyx_23060077_csr_trap

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values are 32 and 64.
REQ-002 SHALL have parameter MTVEC_RESET, default 0, reset value of mtvec.
REQ-003 SHALL have port clock  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port csr_addr  in  12  CSR address for read and write.
REQ-006 SHALL have port csr_op  in  2  operation: 00 none, 01 write, 10 set, 11 clear.
REQ-007 SHALL have port csr_wdata  in  XLEN  operand for csr_op.
REQ-008 SHALL have port csr_rdata  out  XLEN  combinational read of csr_addr, pre-update value.
REQ-009 SHALL have port ecall_i  in  1  ecall commit pulse.
REQ-010 SHALL have port mret_i  in  1  mret commit pulse.
REQ-011 SHALL have port irq_take_i  in  1  core takes the pending interrupt at an instruction boundary.
REQ-012 SHALL have port pc_i  in  XLEN  PC saved to mepc on a trap.
REQ-013 SHALL have port inst_retire_i  in  1  one instruction retired this cycle.
REQ-014 SHALL have port timer_irq_i  in  1  level machine-timer interrupt.
REQ-015 SHALL have port irq_pending_o  out  1  equals mstatus.MIE & mie[7] & timer_irq_i.
REQ-016 SHALL have port trap_pc_o  out  XLEN  trap target address.
REQ-017 SHALL have port mret_pc_o  out  XLEN  current mepc.

Function
REQ-018 SHALL map these registers: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mvendorid 0xF11 = 0x79737978 (read-only), marchid 0xF12 = 0x015FDE6D (read-only).
REQ-019 SHALL read unmapped addresses as 0 and ignore writes to them; writes to read-only registers are ignored.
REQ-020 SHALL compute the new CSR value as wdata for op 01, old|wdata for op 10, and old&~wdata for op 11, applied at the clock edge.
REQ-021 SHALL implement only MIE[3], MPIE[7] and MPP[12:11] of mstatus; MPP always reads 2'b11; all other bits read 0.
REQ-022 SHALL implement only mie[7] (MTIE) in mie; mip reads timer_irq_i at bit 7 and 0 elsewhere.
REQ-023 SHALL force mtvec[1] to 0; mtvec[0] selects the mode: 0 direct, 1 vectored.
REQ-024 SHALL force mepc[0] to 0.
REQ-025 SHALL make trap_pc_o equal to {mtvec[XLEN-1:2],2'b00} in all cases except an interrupt in vectored mode, which uses base + 4*7.
REQ-026 SHALL, on irq_take_i, set mepc to pc_i, set mcause to {1'b1, 7}, copy MIE into MPIE, and clear MIE.
REQ-027 SHALL, on ecall_i, set mepc to pc_i, set mcause to 11, copy MIE into MPIE, and clear MIE.
REQ-028 SHALL, on mret_i, copy MPIE into MIE and set MPIE to 1.
REQ-029 SHALL use the per-cycle priority reset > irq_take_i > ecall_i > mret_i > csr_op; any lower-priority event in the same cycle is dropped entirely.
REQ-030 SHALL drive irq_pending_o low in the cycle after MIE is cleared by a trap, even if timer_irq_i stays high.

Reset
REQ-031 SHALL reset mstatus MIE and MPIE, mie, mscratch, mepc, mcause and the counters to 0, and mtvec to MTVEC_RESET.
REQ-032 SHALL give reset priority over every event; a trap or write in the reset cycle has no effect.
REQ-033 SHALL make all outputs reflect the reset state in the cycle after reset is asserted: irq_pending_o 0, mret_pc_o 0, trap_pc_o MTVEC_RESET with bits [1:0] cleared.

Configuration
REQ-034 SHALL, when CSR_COUNTER_EN is defined, implement 64-bit mcycle (0xB00) incrementing every cycle and 64-bit minstret (0xB02) incrementing on inst_retire_i; with XLEN=32 the high halves are at 0xB80 and 0xB82; both wrap from 2^64-1 to 0; a CSR write to a counter half replaces that half and suppresses the increment that cycle.
REQ-035 SHALL, when CSR_COUNTER_EN is undefined, include no counter storage; 0xB00, 0xB02, 0xB80 and 0xB82 read 0 and ignore writes.

Verification
REQ-036 Bench SHALL write mtvec=0x80000100, set MIE, then pulse ecall_i with pc_i=0x80000010 -> mepc=0x80000010, mcause=11, MIE=0, MPIE=1, trap_pc_o=0x80000100.
REQ-037 Bench SHALL set mtvec=0x80000101, MIE=1, mie=0x80, and hold timer_irq_i=1 -> irq_pending_o=1; then pulse irq_take_i -> mcause=0x80000007, trap_pc_o=0x8000011C, irq_pending_o=0 next cycle.
REQ-038 Bench SHALL pulse mret_i after REQ-036 -> MIE=1, MPIE=1, mret_pc_o=0x80000010.
REQ-039 Bench SHALL assert ecall_i and a csr_op write of mepc=0x1234 in the same cycle -> mepc=pc_i and the write is dropped.
REQ-040 Bench SHALL, with CSR_COUNTER_EN, write mcycle low half=0xFFFFFFFF and high half=0xFFFFFFFF -> both read 0 after one more cycle; without CSR_COUNTER_EN -> 0xB00 reads 0.
REQ-041 Bench SHALL assert reset mid-operation with nonzero mepc and mie -> both read 0 and mtvec reads MTVEC_RESET the next cycle.
